// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// frame constants used by the receiver and its FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic UART_IDLE = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO: rd_data_o always presents the head entry. A push while
// full with no pop is dropped and latches a sticky overflow flag.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     ovf_clr_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             overflow_q;

  logic empty_s;
  logic full_s;
  logic do_pop_s;
  logic do_push_s;
  logic drop_s;

  // Pop only when data exists; a full FIFO still accepts a push if it pops too.
  always_comb begin
    empty_s   = (level_q == '0);
    full_s    = (level_q == FULL_LVL);
    do_pop_s  = pop_i && !empty_s;
    do_push_s = push_i && (!full_s || do_pop_s);
    drop_s    = push_i && full_s && !do_pop_s;
  end

  // Storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
      // A new drop outranks a simultaneous clear.
      if (drop_s) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign rd_valid_o = !empty_s;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first) feeding a show-ahead receive FIFO; reports
// bad stop bits as a one-cycle frame_err pulse.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ena_i,
  input  logic                          rx_i,
  input  logic                          rd_en_i,
  output logic [7:0]                    rd_data_o,
  output logic                          rd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  input  logic                          ovf_clr_i
);

  import uart_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic                 rx_prev_q;
  uart_state_e          state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_q;

  logic fall_s;
  logic cnt_zero_s;
  logic push_s;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_meta_q <= UART_IDLE;
      rx_s_q    <= UART_IDLE;
      rx_prev_q <= UART_IDLE;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall_s     = rx_prev_q && !rx_s_q;
  assign cnt_zero_s = (cnt_q == '0);
  // The push fires on the stop-bit sample edge so the byte is visible one cycle later.
  assign push_s     = ena_i && (state_q == STOP) && cnt_zero_s && (rx_s_q == UART_IDLE);

  // Receive FSM: half-bit wait to the start-bit centre, then one full bit per sample.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (!ena_i) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        bit_idx_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (fall_s) begin
              state_q <= START;
              cnt_q   <= CNT_HALF;
            end
          end
          START: begin
            if (!cnt_zero_s) begin
              cnt_q <= cnt_q - CNT_ONE;
            end else if (rx_s_q == UART_IDLE) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              cnt_q     <= CNT_FULL;
              bit_idx_q <= '0;
            end
          end
          DATA: begin
            if (!cnt_zero_s) begin
              cnt_q <= cnt_q - CNT_ONE;
            end else begin
              shift_q[bit_idx_q] <= rx_s_q;
              cnt_q              <= CNT_FULL;
              if (bit_idx_q == LAST_BIT) begin
                state_q <= STOP;
              end else begin
                bit_idx_q <= bit_idx_q + IDX_ONE;
              end
            end
          end
          STOP: begin
            if (!cnt_zero_s) begin
              cnt_q <= cnt_q - CNT_ONE;
            end else if (rx_s_q == UART_IDLE) begin
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (rx_s_q == UART_IDLE) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign frame_err_o = frame_err_q;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_s),
    .push_data_i (shift_q),
    .pop_i       (rd_en_i),
    .ovf_clr_i   (ovf_clr_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: a frame-level reference model (byte queue
// plus scheduled push/error events) is compared against the DUT every cycle.
module tb_uart_rx_fifo;

  localparam int C  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          rx;
  logic          rd_en;
  logic          ovf_clr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic          frame_err;
  logic          overflow;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ena_i       (ena),
    .rx_i        (rx),
    .rd_en_i     (rd_en),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .level_o     (level),
    .frame_err_o (frame_err),
    .overflow_o  (overflow),
    .ovf_clr_i   (ovf_clr)
  );

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         ferr_seen = 0;
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_ferr = 1'b0;
  logic [7:0] push_at[int];
  bit         err_at[int];

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", nm, cyc, got, exp);
  endtask

  // Reference model: the FIFO is a queue; receiver outcomes are events keyed by edge number.
  initial forever begin
    bit pop;
    bit drop;
    @(posedge clk);
    cyc = cyc + 1;
    if (!rst_n) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
      push_at.delete();
      err_at.delete();
    end else begin
      pop    = rd_en && (mq.size() > 0);
      drop   = 1'b0;
      m_ferr = err_at.exists(cyc);
      if (pop) void'(mq.pop_front());
      if (push_at.exists(cyc)) begin
        if (mq.size() < D) mq.push_back(push_at[cyc]);
        else drop = 1'b1;
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (drop) m_ovf = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (cyc >= 1) begin
      check("rd_valid", int'(rd_valid), int'(mq.size() > 0));
      check("level", int'(level), mq.size());
      check("frame_err", int'(frame_err), int'(m_ferr));
      check("overflow", int'(overflow), int'(m_ovf));
      if (mq.size() > 0) check("rd_data", int'(rd_data), int'(mq[0]));
      if (frame_err) ferr_seen++;
    end
  end

  task automatic rand_ctl();
    rd_en   = ($urandom_range(0, 2) == 0);
    ovf_clr = ($urandom_range(0, 15) == 0);
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      rx = 1'b1;
      if (rnd) rand_ctl();
      else begin rd_en = 1'b0; ovf_clr = 1'b0; end
      @(negedge clk);
    end
  endtask

  // act: 0 normal, 1 drop ena at bit 'cut', 2 pulse reset at bit 'cut'.
  // A frame whose start bit is first sampled on edge k is decided on edge k+2+C/2+9C
  // (2 sync flops, half a bit to the start centre, then 9 full bits).
  task automatic send(input logic [7:0] b, input bit stop_bit, input bit rnd,
                      input int act, input int cut);
    int k;
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    k = cyc + 1;
    if (act == 0 && ena) begin
      if (stop_bit) push_at[k + 2 + C/2 + 9*C] = b;
      else err_at[k + 2 + C/2 + 9*C] = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < C; j++) begin
        rx    = bits[i];
        rst_n = 1'b1;
        if (rnd) rand_ctl();
        else begin rd_en = 1'b0; ovf_clr = 1'b0; end
        if (i == cut && j == C/2) begin
          if (act == 1) ena = 1'b0;
          else if (act == 2) rst_n = 1'b0;
        end
        @(negedge clk);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic pop_expect(input string nm, input logic [7:0] exp);
    check(nm, int'(rd_data), int'(exp));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; rx = 1'b1; rd_en = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(rd_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_data", int'(rd_data), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_ferr", int'(frame_err), 0);
    rst_n = 1'b1;
    idle(C, 1'b0);

    // Single frame
    send(8'hA5, 1'b1, 1'b0, 0, 0);
    check("a5_valid", int'(rd_valid), 1);
    check("a5_level", int'(level), 1);
    check("a5_ferr_cnt", ferr_seen, 0);
    pop_expect("a5_data", 8'hA5);

    // Back-to-back frames, then in-order drain
    send(8'h31, 1'b1, 1'b0, 0, 0);
    send(8'h32, 1'b1, 1'b0, 0, 0);
    send(8'h33, 1'b1, 1'b0, 0, 0);
    check("b2b_level", int'(level), 3);
    pop_expect("b2b_0", 8'h31);
    pop_expect("b2b_1", 8'h32);
    pop_expect("b2b_2", 8'h33);
    check("b2b_empty", int'(rd_valid), 0);

    // Overflow: fifth byte dropped, sticky flag, then cleared
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, 0, 0);
    check("ovf_level", int'(level), D);
    check("ovf_flag", int'(overflow), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", int'(overflow), 0);
    for (int i = 1; i <= 4; i++) pop_expect("ovf_data", 8'(i));
    check("ovf_empty", int'(rd_valid), 0);

    // Bad stop bit, line held low (break), then recovery
    send(8'h5A, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3*C; i++) begin rx = 1'b0; @(negedge clk); end
    check("ferr_cnt", ferr_seen, 1);
    check("ferr_level", int'(level), 0);
    idle(C, 1'b0);
    send(8'h11, 1'b1, 1'b0, 0, 0);
    check("ferr_ferr_cnt", ferr_seen, 1);
    pop_expect("recover_data", 8'h11);

    // Two-cycle glitch is rejected at the start-bit centre
    rx = 1'b0; @(negedge clk); @(negedge clk);
    idle(2*C, 1'b0);
    check("glitch_level", int'(level), 0);
    check("glitch_ferr_cnt", ferr_seen, 1);

    // Reset mid-DATA loses queued data and the partial frame
    send(8'h77, 1'b1, 1'b0, 0, 0);
    check("prerst_level", int'(level), 1);
    send(8'hF0, 1'b1, 1'b0, 2, 6);
    check("midrst_level", int'(level), 0);
    check("midrst_valid", int'(rd_valid), 0);
    check("midrst_data", int'(rd_data), 0);
    idle(C, 1'b0);

    // Dropping ena mid-frame suppresses the push
    send(8'h3C, 1'b1, 1'b0, 1, 3);
    idle(C, 1'b0);
    ena = 1'b1;
    idle(C, 1'b0);
    check("ena_level", int'(level), 0);
    send(8'h42, 1'b1, 1'b0, 0, 0);
    pop_expect("ena_recover", 8'h42);

    // Random traffic with random pops, clears, gaps and framing errors
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      bit sb;
      b  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      send(b, sb, 1'b1, 0, 0);
      if (sb) idle($urandom_range(0, 12), 1'b1);
      else idle(C + $urandom_range(0, 8), 1'b1);
    end
    idle(2*C, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
